// File: rtl/mem2rw_pkg.sv
// mem2rw_pkg
//   Shared constants and types for the two-port 32x64 memory front-end.
//   MEM2RW_AW / MEM2RW_DW : default address / data widths of the memory.
//   mem2rw_req_t          : one request beat {addr, wdata, we}.
//   mem2rw_rdata_t        : one read-data word.
package mem2rw_pkg;

    localparam int MEM2RW_AW = 5;
    localparam int MEM2RW_DW = 64;

    typedef struct packed {
        logic [MEM2RW_AW-1:0] addr;
        logic [MEM2RW_DW-1:0] wdata;
        logic                 we;
    } mem2rw_req_t;

    typedef logic [MEM2RW_DW-1:0] mem2rw_rdata_t;

endpackage

// File: rtl/mem2rw_rsp_fifo.sv
// mem2rw_rsp_fifo
//   Small circular-buffer FIFO holding read responses for one channel.
//   Ports:
//     clock     : rising-edge clock
//     reset     : asynchronous active-low reset (clears pointers, count, entries)
//     push      : write push_data at the tail this cycle
//     push_data : data to store
//     pop       : drop the head entry this cycle (only meaningful when !empty)
//     count     : number of stored entries (0..DEPTH)
//     head_data : head entry; stable until popped
//     empty     : count == 0
//   The caller guarantees no push while full without a simultaneous pop.
module mem2rw_rsp_fifo #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head_data,
    output logic          empty
);

    logic [DW-1:0] entry_q [DEPTH];
    logic [DW-1:0] entry_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end

        if (push) begin
            entry_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign count     = count_q;
    assign empty     = (count_q == '0);
    // Entries are cleared on reset, so the head reads 0 out of reset.
    assign head_data = entry_q[rd_ptr_q];

`ifndef SYNTHESIS
    // Overflow can only come from a broken credit scheme upstream.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && (count_q == CW'(DEPTH))));
`endif

endmodule

// File: rtl/mem2rw_req_frontend.sv
// mem2rw_req_frontend
//   Front-end for a two-port 32x64 read/write memory with 1-cycle registered
//   read. Channel N (valid/ready request + valid/ready response) drives memory
//   port N only; the two channels are independent.
//   Ports:
//     clock, reset            : clock, asynchronous active-low reset
//     cN_req_valid/ready      : request handshake
//     cN_req_addr/wdata/we    : request payload (we=1 write, no response)
//     cN_rsp_valid/ready      : response handshake
//     cN_rsp_rdata            : response read data
//     pNaddr/pNwdata/pNwe     : raw memory port N drive
//     pNrdata                 : memory port N registered read data
//     collision_err           : only with MEM2RW_COLLISION_FLAG_EN defined; sticky
//                               flag for same-address same-cycle accesses with
//                               at least one write on both channels.
//   Optional build macro: MEM2RW_COLLISION_FLAG_EN.
module mem2rw_req_frontend
    import mem2rw_pkg::*;
#(
    parameter int AW        = MEM2RW_AW,
    parameter int DW        = MEM2RW_DW,
    parameter int RSP_DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          c1_req_valid,
    output logic          c1_req_ready,
    input  logic [AW-1:0] c1_req_addr,
    input  logic [DW-1:0] c1_req_wdata,
    input  logic          c1_req_we,
    output logic          c1_rsp_valid,
    input  logic          c1_rsp_ready,
    output logic [DW-1:0] c1_rsp_rdata,

    input  logic          c2_req_valid,
    output logic          c2_req_ready,
    input  logic [AW-1:0] c2_req_addr,
    input  logic [DW-1:0] c2_req_wdata,
    input  logic          c2_req_we,
    output logic          c2_rsp_valid,
    input  logic          c2_rsp_ready,
    output logic [DW-1:0] c2_rsp_rdata,

    output logic [AW-1:0] p1addr,
    output logic [DW-1:0] p1wdata,
    output logic          p1we,
    input  logic [DW-1:0] p1rdata,

    output logic [AW-1:0] p2addr,
    output logic [DW-1:0] p2wdata,
    output logic          p2we,
    input  logic [DW-1:0] p2rdata
`ifdef MEM2RW_COLLISION_FLAG_EN
    ,
    output logic          collision_err
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    // Index 0 = channel/port 1, index 1 = channel/port 2.
    mem2rw_req_t   [1:0] req;
    mem2rw_rdata_t [1:0] prdata;
    mem2rw_rdata_t [1:0] rsp_rdata;
    logic          [1:0] req_valid;
    logic          [1:0] req_ready;
    logic          [1:0] fire;
    logic          [1:0] pwe;
    logic          [1:0] rsp_valid;
    logic          [1:0] rsp_ready;

    assign req[0]    = '{addr: c1_req_addr, wdata: c1_req_wdata, we: c1_req_we};
    assign req[1]    = '{addr: c2_req_addr, wdata: c2_req_wdata, we: c2_req_we};
    assign req_valid = {c2_req_valid, c1_req_valid};
    assign rsp_ready = {c2_rsp_ready, c1_rsp_ready};
    assign prdata[0] = p1rdata;
    assign prdata[1] = p2rdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic          inflight_q, inflight_d;
        logic [CW-1:0] fifo_count;
        logic          fifo_empty;
        logic          pop;

        // A fired read holds one FIFO slot from fire until its response is
        // popped, so counting inflight plus stored entries can never overflow.
        // Writes are also stalled when credits run out to keep ordering.
        assign req_ready[gi] = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q})
                               < (CW+1)'(RSP_DEPTH);
        assign fire[gi]      = req_valid[gi] & req_ready[gi];
        assign pwe[gi]       = fire[gi] & req[gi].we;
        assign pop           = rsp_valid[gi] & rsp_ready[gi];
        assign rsp_valid[gi] = ~fifo_empty;

        // The memory registers the read address at the fire edge; its data
        // is present on pNrdata during the following cycle only.
        always_comb begin
            inflight_d = fire[gi] & ~req[gi].we;
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= inflight_d;
            end
        end

        mem2rw_rsp_fifo #(
            .DW    (DW),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (inflight_q),
            .push_data (prdata[gi]),
            .pop       (pop),
            .count     (fifo_count),
            .head_data (rsp_rdata[gi]),
            .empty     (fifo_empty)
        );
    end

    assign c1_req_ready = req_ready[0];
    assign c2_req_ready = req_ready[1];
    assign c1_rsp_valid = rsp_valid[0];
    assign c2_rsp_valid = rsp_valid[1];
    assign c1_rsp_rdata = rsp_rdata[0];
    assign c2_rsp_rdata = rsp_rdata[1];

    // Address and data pass straight through; only the write enable is
    // qualified, so a non-firing cycle is a harmless ignored read.
    assign p1addr  = req[0].addr;
    assign p1wdata = req[0].wdata;
    assign p1we    = pwe[0];
    assign p2addr  = req[1].addr;
    assign p2wdata = req[1].wdata;
    assign p2we    = pwe[1];

`ifdef MEM2RW_COLLISION_FLAG_EN
    logic collision_q, collision_d;

    always_comb begin
        collision_d = collision_q;
        if (fire[0] && fire[1] && (req[0].addr == req[1].addr)
            && (req[0].we || req[1].we)) begin
            collision_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision_err = collision_q;
`endif

endmodule

// File: tb/tb_mem2rw_req_frontend.sv
// tb_mem2rw_req_frontend
//   Bench for mem2rw_req_frontend with a behavioural two-port memory
//   (registered read, write-first, port 2 wins on same-address writes).
//   A transaction-level model (per-channel queues of outstanding reads with
//   their fire cycle) checks every cycle; directed sequences and a vector
//   table cover the latency, backpressure, throughput and reset corners.
module tb_mem2rw_req_frontend;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          c1_req_valid, c1_req_ready, c1_req_we, c1_rsp_valid, c1_rsp_ready;
    logic [AW-1:0] c1_req_addr;
    logic [DW-1:0] c1_req_wdata, c1_rsp_rdata;
    logic          c2_req_valid, c2_req_ready, c2_req_we, c2_rsp_valid, c2_rsp_ready;
    logic [AW-1:0] c2_req_addr;
    logic [DW-1:0] c2_req_wdata, c2_rsp_rdata;
    logic [AW-1:0] p1addr, p2addr;
    logic [DW-1:0] p1wdata, p2wdata, p1rdata, p2rdata;
    logic          p1we, p2we;
`ifdef MEM2RW_COLLISION_FLAG_EN
    logic          collision_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;

    mem2rw_req_frontend #(.AW(AW), .DW(DW), .RSP_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .c1_req_valid (c1_req_valid),
        .c1_req_ready (c1_req_ready),
        .c1_req_addr  (c1_req_addr),
        .c1_req_wdata (c1_req_wdata),
        .c1_req_we    (c1_req_we),
        .c1_rsp_valid (c1_rsp_valid),
        .c1_rsp_ready (c1_rsp_ready),
        .c1_rsp_rdata (c1_rsp_rdata),
        .c2_req_valid (c2_req_valid),
        .c2_req_ready (c2_req_ready),
        .c2_req_addr  (c2_req_addr),
        .c2_req_wdata (c2_req_wdata),
        .c2_req_we    (c2_req_we),
        .c2_rsp_valid (c2_rsp_valid),
        .c2_rsp_ready (c2_rsp_ready),
        .c2_rsp_rdata (c2_rsp_rdata),
        .p1addr       (p1addr),
        .p1wdata      (p1wdata),
        .p1we         (p1we),
        .p1rdata      (p1rdata),
        .p2addr       (p2addr),
        .p2wdata      (p2wdata),
        .p2we         (p2we),
        .p2rdata      (p2rdata)
`ifdef MEM2RW_COLLISION_FLAG_EN
        ,
        .collision_err (collision_err)
`endif
    );

    // ---------------- behavioural memory ----------------
    logic [DW-1:0] mem [32];

    function automatic logic [DW-1:0] mem_read_wf(input logic [AW-1:0] a);
        if (p2we && p2addr == a) return p2wdata;
        if (p1we && p1addr == a) return p1wdata;
        return mem[a];
    endfunction

    always @(posedge clock) begin
        if (p1we) mem[p1addr] <= p1wdata;
        if (p2we) mem[p2addr] <= p2wdata;
        p1rdata <= mem_read_wf(p1addr);
        p2rdata <= mem_read_wf(p2addr);
    end

    function automatic logic [DW-1:0] pattern(input int i);
        return {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i * 3)};
    endfunction

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            fc;
    } ent_t;

    ent_t          mq [2][$];
    logic [DW-1:0] ref_mem [32];
    bit            coll_m;

    logic [1:0]    s_v, s_we, s_rdy, s_rv, s_rr, s_pwe, f;
    logic [AW-1:0] s_a [2];
    logic [AW-1:0] s_pa [2];
    logic [DW-1:0] s_d [2];
    logic [DW-1:0] s_rd [2];

    always @(negedge clock) begin
        cyc++;
        s_v   = {c2_req_valid, c1_req_valid};
        s_we  = {c2_req_we, c1_req_we};
        s_rdy = {c2_req_ready, c1_req_ready};
        s_rv  = {c2_rsp_valid, c1_rsp_valid};
        s_rr  = {c2_rsp_ready, c1_rsp_ready};
        s_pwe = {p2we, p1we};
        s_a[0] = c1_req_addr;  s_a[1] = c2_req_addr;
        s_pa[0] = p1addr;      s_pa[1] = p2addr;
        s_d[0] = c1_req_wdata; s_d[1] = c2_req_wdata;
        s_rd[0] = c1_rsp_rdata; s_rd[1] = c2_rsp_rdata;
        if (!reset) begin
            coll_m = 1'b0;
            for (int n = 0; n < 2; n++) begin
                mq[n].delete();
                chk("rst_req_ready", 64'(s_rdy[n]), 64'd1);
                chk("rst_rsp_valid", 64'(s_rv[n]), 64'd0);
                chk("rst_rsp_rdata", s_rd[n], 64'd0);
                chk("rst_pwe", 64'(s_pwe[n]), 64'(s_v[n] & s_we[n]));
            end
`ifdef MEM2RW_COLLISION_FLAG_EN
            chk("rst_collision", 64'(collision_err), 64'd0);
`endif
        end else begin
            for (int n = 0; n < 2; n++) begin
                logic exp_rdy, exp_v;
                exp_rdy = (mq[n].size() < DEPTH);
                chk("req_ready", 64'(s_rdy[n]), 64'(exp_rdy));
                f[n] = s_v[n] & exp_rdy;
                chk("pwe", 64'(s_pwe[n]), 64'(f[n] & s_we[n]));
                chk("paddr", 64'(s_pa[n]), 64'(s_a[n]));
                exp_v = (mq[n].size() > 0) && (cyc >= mq[n][0].fc + 2);
                chk("rsp_valid", 64'(s_rv[n]), 64'(exp_v));
                if (exp_v) begin
                    chk("rsp_rdata", s_rd[n], mq[n][0].data);
                    if (s_rr[n]) void'(mq[n].pop_front());
                end
            end
            chk("p1wdata", p1wdata, c1_req_wdata);
            chk("p2wdata", p2wdata, c2_req_wdata);
`ifdef MEM2RW_COLLISION_FLAG_EN
            chk("collision", 64'(collision_err), 64'(coll_m));
`endif
            // Writes land first (port 2 last so it wins), then reads see them.
            if (f[0] && s_we[0]) ref_mem[s_a[0]] = s_d[0];
            if (f[1] && s_we[1]) ref_mem[s_a[1]] = s_d[1];
            for (int n = 0; n < 2; n++) begin
                if (f[n] && !s_we[n]) mq[n].push_back('{ref_mem[s_a[n]], cyc});
            end
            if (f[0] && f[1] && s_a[0] == s_a[1] && (s_we[0] || s_we[1])) coll_m = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        c1_req_valid = 1'b0; c1_req_we = 1'b0;
        c2_req_valid = 1'b0; c2_req_we = 1'b0;
    endtask

    typedef struct {
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          v2, we2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
        logic          e_p1we, e_p2we;
    } vec_t;

    vec_t tbl [8];
    logic [DW-1:0] got1 [$];
    logic [DW-1:0] got2 [$];

    initial begin
        int nxt, got, first, last;
        for (int i = 0; i < 32; i++) begin
            mem[i]     = pattern(i);
            ref_mem[i] = pattern(i);
        end
        c1_req_valid = 0; c1_req_we = 0; c1_req_addr = '0; c1_req_wdata = '0; c1_rsp_ready = 1;
        c2_req_valid = 0; c2_req_we = 0; c2_req_addr = '0; c2_req_wdata = '0; c2_rsp_ready = 1;

        // Reset state
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_ready", 64'(c1_req_ready), 64'd1);
        chk("reset_p1we", 64'(p1we), 64'd0);
        @(negedge clock);
        step();
        reset = 1'b1;

        // Write then read-back with exact 2-cycle latency
        step();
        c1_req_valid = 1; c1_req_we = 1; c1_req_addr = 5'd3; c1_req_wdata = 64'hDEADBEEF_00000001;
        @(negedge clock);
        chk("wr_p1we", 64'(p1we), 64'd1);
        step();
        c1_req_we = 0;
        @(negedge clock);
        chk("rd_p1we", 64'(p1we), 64'd0);
        chk("rd_fire", 64'(c1_req_ready), 64'd1);
        step();
        idle();
        @(negedge clock);
        chk("lat_t1_valid", 64'(c1_rsp_valid), 64'd0);
        step();
        @(negedge clock);
        chk("lat_t2_valid", 64'(c1_rsp_valid), 64'd1);
        chk("lat_t2_rdata", c1_rsp_rdata, 64'hDEADBEEF_00000001);
        chk("lat_t2_p1we", 64'(p1we), 64'd0);

        // Backpressure on channel 2
        c2_rsp_ready = 0;
        nxt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            c2_req_valid = (nxt < 8); c2_req_addr = 5'(nxt);
            @(negedge clock);
            if (c2_req_valid && c2_req_ready) nxt++;
        end
        chk("bp_accepted", 64'(nxt), 64'd4);
        chk("bp_ready_low", 64'(c2_req_ready), 64'd0);
        got = 0;
        for (int k = 0; k < 40 && got < 8; k++) begin
            step();
            c2_rsp_ready = 1;
            c2_req_valid = (nxt < 8); c2_req_addr = 5'(nxt);
            @(negedge clock);
            if (c2_rsp_valid) begin
                chk("bp_order", c2_rsp_rdata, ref_mem[got]);
                got++;
            end
            if (c2_req_valid && c2_req_ready) nxt++;
        end
        chk("bp_count", 64'(got), 64'd8);
        step(); idle();

        // Full-throughput reads on channel 1
        nxt = 0; got = 0; first = -1; last = -1;
        for (int k = 0; k < 80 && got < 32; k++) begin
            step();
            c1_req_valid = (nxt < 32); c1_req_we = 0; c1_req_addr = 5'(nxt);
            @(negedge clock);
            if (c1_rsp_valid) begin
                if (first < 0) first = k;
                last = k;
                chk("tp_data", c1_rsp_rdata, ref_mem[got]);
                got++;
            end
            if (c1_req_valid && c1_req_ready) nxt++;
        end
        chk("tp_count", 64'(got), 64'd32);
        chk("tp_first", 64'(first), 64'd2);
        chk("tp_span", 64'(last - first), 64'd31);
        step(); idle();
        for (int k = 0; k < 4; k++) step();
`ifdef MEM2RW_COLLISION_FLAG_EN
        @(negedge clock);
        chk("coll_clear_before", 64'(collision_err), 64'd0);
`endif

        // Vector table: same-cycle write/write and write/read on both ports
        tbl[0] = '{1, 1, 5'd7,  64'h1, 1, 1, 5'd7,  64'h2,   1, 1};
        tbl[1] = '{1, 0, 5'd7,  64'h0, 0, 0, 5'd0,  64'h0,   0, 0};
        tbl[2] = '{1, 1, 5'd9,  64'h55, 1, 0, 5'd9, 64'h0,   1, 0};
        tbl[3] = '{0, 0, 5'd0,  64'h0, 0, 0, 5'd0,  64'h0,   0, 0};
        tbl[4] = '{0, 1, 5'd20, 64'hAA, 1, 1, 5'd20, 64'hBEEF, 0, 1};
        tbl[5] = '{1, 0, 5'd20, 64'h0, 1, 0, 5'd20, 64'h0,   0, 0};
        tbl[6] = '{0, 0, 5'd0,  64'h0, 0, 0, 5'd0,  64'h0,   0, 0};
        tbl[7] = '{0, 0, 5'd0,  64'h0, 0, 0, 5'd0,  64'h0,   0, 0};
        for (int i = 0; i < 8; i++) begin
            step();
            c1_req_valid = tbl[i].v1; c1_req_we = tbl[i].we1;
            c1_req_addr = tbl[i].a1;  c1_req_wdata = tbl[i].d1;
            c2_req_valid = tbl[i].v2; c2_req_we = tbl[i].we2;
            c2_req_addr = tbl[i].a2;  c2_req_wdata = tbl[i].d2;
            @(negedge clock);
            chk("tbl_p1we", 64'(p1we), 64'(tbl[i].e_p1we));
            chk("tbl_p2we", 64'(p2we), 64'(tbl[i].e_p2we));
            if (c1_rsp_valid) got1.push_back(c1_rsp_rdata);
            if (c2_rsp_valid) got2.push_back(c2_rsp_rdata);
        end
        chk("tbl_c1_n", 64'(got1.size()), 64'd2);
        chk("tbl_c2_n", 64'(got2.size()), 64'd2);
        if (got1.size() == 2) begin
            chk("tbl_ww_port2_wins", got1[0], 64'h2);
            chk("tbl_c1_rd20", got1[1], 64'hBEEF);
        end
        if (got2.size() == 2) begin
            chk("tbl_wr_first", got2[0], 64'h55);
            chk("tbl_c2_rd20", got2[1], 64'hBEEF);
        end
`ifdef MEM2RW_COLLISION_FLAG_EN
        chk("coll_set", 64'(collision_err), 64'd1);
`endif

        // Reset while reads are in flight
        step();
        idle();
        c1_req_valid = 1; c1_req_we = 0; c1_req_addr = 5'd1;
        step();
        c1_req_addr = 5'd2;
        step();
        idle();
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 64'(c1_rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(c1_req_ready), 64'd1);
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            chk("no_stale_rsp", 64'(c1_rsp_valid), 64'd0);
        end

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            step();
            c1_req_valid = ($urandom_range(0, 9) < 7); c1_req_we = ($urandom_range(0, 9) < 4);
            c1_req_addr = 5'($urandom_range(0, 7)); c1_req_wdata = {$urandom, $urandom};
            c2_req_valid = ($urandom_range(0, 9) < 7); c2_req_we = ($urandom_range(0, 9) < 4);
            c2_req_addr = 5'($urandom_range(0, 7)); c2_req_wdata = {$urandom, $urandom};
            c1_rsp_ready = ($urandom_range(0, 9) < 6);
            c2_rsp_ready = ($urandom_range(0, 9) < 6);
        end
        step();
        idle();
        c1_rsp_ready = 1; c2_rsp_ready = 1;
        for (int k = 0; k < 10; k++) step();
        @(negedge clock);
        chk("drain_c1", 64'(mq[0].size()), 64'd0);
        chk("drain_c2", 64'(mq[1].size()), 64'd0);
        chk("drain_valid", 64'({c2_rsp_valid, c1_rsp_valid}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem2rw_req_frontend.md
Name: mem2rw_req_frontend

Overview:
- Upstream front-end for the two-port 32x64 read/write memory.
- Converts two independent valid/ready request channels into the memory's raw port signals (address, write data, write enable), one channel per memory port.
- Tracks the memory's 1-cycle registered read latency and captures read data into a per-channel response FIFO.
- Uses credit-based request acceptance, so response backpressure never drops data.

Parameters:
- AW, 5, address width; must match the memory depth (32 words).
- DW, 64, data width.
- RSP_DEPTH, 4, entries per channel response FIFO; minimum 2; 3 or more needed for full read throughput.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- c1_req_valid  in  1  channel 1 request valid.
- c1_req_ready  out  1  channel 1 request accepted when valid&ready.
- c1_req_addr  in  AW  channel 1 word address.
- c1_req_wdata  in  DW  channel 1 write data.
- c1_req_we  in  1  1=write (no response), 0=read.
- c1_rsp_valid  out  1  channel 1 read data valid.
- c1_rsp_ready  in  1  channel 1 consumer ready.
- c1_rsp_rdata  out  DW  channel 1 read data.
- c2_*  same set as c1_*, for channel 2.
- p1addr  out  AW  to memory port 1 address.
- p1wdata  out  DW  to memory port 1 write data.
- p1we  out  1  to memory port 1 write enable.
- p1rdata  in  DW  from memory port 1 read data.
- p2addr, p2wdata, p2we, p2rdata  same roles for memory port 2.

Behaviour:
- Channels 1 and 2 are fully independent; channel N drives memory port N only.
- Reset (async assert, sync deassert at the user's discretion) clears all per-channel state:
  - inflight=0, FIFO count=0, pointers=0.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, pNwe=0.
- Credit rule: req_ready = (fifo_count + inflight) < RSP_DEPTH.
  - req_ready does not depend on req_valid, req_we, or a same-cycle response pop.
  - req_ready deasserts when credits are exhausted, even for writes; this preserves per-channel ordering.
- Fire = req_valid & req_ready. Memory port drive is combinational from the request inputs:
  - pNaddr = req_addr and pNwdata = req_wdata, always.
  - pNwe = fire & req_we.
  - When the channel is not firing, pNwe=0, so the memory performs a don't-care read; its data is ignored.
- Read latency:
  - Read fire in cycle t sets inflight for cycle t+1.
  - In t+1, pNrdata is valid and is written into the FIFO at the end of t+1.
  - rsp_valid is asserted from t+2.
  - Minimum request-to-response latency is 2 cycles.
- Response FIFO:
  - Standard circular buffer; pointers wrap modulo RSP_DEPTH.
  - rsp_rdata is driven from the head entry; it holds stable while rsp_valid=1 and rsp_ready=0.
  - Push and pop in the same cycle leave the count unchanged.
  - The FIFO never overflows: the credit rule guarantees it. Overflow is a design error, flagged by a simulation assertion.
- Write: fire with we=1 updates memory at the end of cycle t. No response and no credit consumed beyond the fire cycle.
- Memory is write-first across ports: a read registered in cycle t returns data written in cycle t by either port.
- Both channels writing the same address in the same cycle: port 2 data wins (memory behaviour). The front-end does not arbitrate.
- Reset asserted mid-operation: in-flight reads and buffered responses are discarded with no response issued; clients must reissue.

Optional Feature:
- Macro MEM2RW_COLLISION_FLAG_EN.
- Defined:
  - Adds output collision_err (1 bit, reset 0, sticky until reset).
  - Set at the end of any cycle where both channels fire, c1_req_addr==c2_req_addr, and at least one of them is a write.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package mem2rw_pkg:
  - Constants MEM2RW_AW=5, MEM2RW_DW=64.
  - Typedef mem2rw_req_t {addr, wdata, we}.
  - Typedef mem2rw_rdata_t (DW-bit vector).
- Sub-module mem2rw_rsp_fifo (parameters DW, DEPTH): push/pop/count/head; instantiated once per channel.
- Credit and inflight logic stay in the top module.

Test Plan:
- Reset, then c1 write addr 3 data 0xDEADBEEF_00000001, then c1 read addr 3 -> c1_rsp_valid exactly 2 cycles after the read fire, rdata 0xDEADBEEF_00000001; p1we high only in the write cycle.
- c2_rsp_ready held 0, c2 issues back-to-back reads of addrs 0..7 -> c2_req_ready drops after 4 accepted; raise ready -> 4 responses in order, then the remaining 4 are accepted and returned in order.
- c1_rsp_ready tied 1, continuous c1 reads of addrs 0..31 -> one response per cycle in steady state, no bubbles after the first.
- Both channels write addr 7 in the same cycle (c1 0x1, c2 0x2), then c1 reads 7 -> 0x2; collision_err=1 when MEM2RW_COLLISION_FLAG_EN is defined.
- c1 writes addr 9 with 0x55 while c2 reads addr 9 in the same cycle -> c2 response 0x55.
- Two reads fired, reset asserted in the inflight cycle -> rsp_valid=0 immediately, req_ready=1, and no stale response after reset release.
